// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for a 5-stage MIPS pipeline, sitting beside ID.
// Tracks destination registers of EX/MEM/WB in a private shadow pipeline.
module hazard_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_type,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_rd,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             br_taken,
   input  logic             mem_wait,
   output logic             stall_if,
   output logic             bubble_ex,
   output logic             flush_if_id,
   output logic             freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             br_fwd_a,
   output logic             br_fwd_b,
   output logic [1:0]       hz_state,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {StRun = 2'b00, StHaz = 2'b01, StFrz = 2'b10} hz_state_e;

   logic       ex_vld, mem_vld, wb_vld;
   logic [4:0] ex_dst, mem_dst, wb_dst;
   logic       ex_ld, mem_ld;
   logic [4:0] ex_rs, ex_rt;
   logic       ex_use_rs, ex_use_rt;

   logic       id_wr, is_br, ex_hit, mem_hit_rs, mem_hit_rt;
   logic       load_use, br_haz, hazard, wait_act;
   logic [4:0] id_dst;
   hz_state_e  state;

   function automatic logic hit(logic vld, logic [4:0] dst, logic [4:0] src, logic use_src);
      return vld & use_src & (dst == src) & (src != 5'd0);
   endfunction

   always_comb begin
      id_dst = 5'd0;
      id_wr  = 1'b0;
      unique case (id_type)
         4'd1:       begin id_dst = id_rd; id_wr = 1'b1; end
         4'd2, 4'd3: begin id_dst = id_rt; id_wr = 1'b1; end
         default:    ;
      endcase
      id_wr = id_wr & id_valid & (id_dst != 5'd0);
   end

   assign is_br      = (id_type == 4'd5);
   assign ex_hit     = hit(ex_vld, ex_dst, id_rs, id_use_rs) | hit(ex_vld, ex_dst, id_rt, id_use_rt);
   assign mem_hit_rs = hit(mem_vld, mem_dst, id_rs, id_use_rs);
   assign mem_hit_rt = hit(mem_vld, mem_dst, id_rt, id_use_rt);
   assign load_use   = ex_ld & ex_hit;
   assign br_haz     = is_br & (ex_hit | (mem_ld & (mem_hit_rs | mem_hit_rt)));
   assign hazard     = ~rst & id_valid & (load_use | br_haz);
   assign wait_act   = ~rst & mem_wait;

   assign freeze      = wait_act;
   assign stall_if    = wait_act | hazard;
   assign bubble_ex   = hazard & ~wait_act;
   assign flush_if_id = ~rst & id_valid & is_br & br_taken & ~hazard & ~mem_wait;
   assign br_fwd_a    = ~rst & id_valid & is_br & ~mem_ld & mem_hit_rs;
   assign br_fwd_b    = ~rst & id_valid & is_br & ~mem_ld & mem_hit_rt;

   // Loads in MEM have no data yet; they reach EX only through the WB path.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (!rst) begin
         if (hit(mem_vld & ~mem_ld, mem_dst, ex_rs, ex_use_rs))  fwd_a = 2'b01;
         else if (hit(wb_vld, wb_dst, ex_rs, ex_use_rs))         fwd_a = 2'b10;
         if (hit(mem_vld & ~mem_ld, mem_dst, ex_rt, ex_use_rt))  fwd_b = 2'b01;
         else if (hit(wb_vld, wb_dst, ex_rt, ex_use_rt))         fwd_b = 2'b10;
      end
   end

   // Status reports the condition of the current cycle, so it is decoded, not delayed.
   always_comb begin
      if (wait_act)    state = StFrz;
      else if (hazard) state = StHaz;
      else             state = StRun;
   end
   assign hz_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_vld    <= 1'b0;
         ex_dst    <= 5'd0;
         ex_ld     <= 1'b0;
         ex_rs     <= 5'd0;
         ex_rt     <= 5'd0;
         ex_use_rs <= 1'b0;
         ex_use_rt <= 1'b0;
         mem_vld   <= 1'b0;
         mem_dst   <= 5'd0;
         mem_ld    <= 1'b0;
         wb_vld    <= 1'b0;
         wb_dst    <= 5'd0;
      end else if (!mem_wait) begin
         wb_vld    <= mem_vld;
         wb_dst    <= mem_dst;
         mem_vld   <= ex_vld;
         mem_dst   <= ex_dst;
         mem_ld    <= ex_ld;
         ex_vld    <= id_wr & ~hazard;
         ex_dst    <= id_dst;
         ex_ld     <= id_wr & ~hazard & (id_type == 4'd3);
         ex_rs     <= id_rs;
         ex_rt     <= id_rt;
         ex_use_rs <= id_valid & ~hazard & id_use_rs;
         ex_use_rt <= id_valid & ~hazard & id_use_rt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                              stall_cnt <= '0;
      else if (stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: driver queues hand-computed outputs,
// a negedge monitor pops and compares. A second 3-bit-counter instance checks saturation.
module tb_hazard_ctrl;

   typedef struct {
      logic       v;
      logic [3:0] t;
      logic [4:0] rs, rt, rd;
      logic       urs, urt;
   } ins_t;

   typedef struct {
      string       nm;
      logic [11:0] v;
      logic [15:0] cnt;
      logic [2:0]  cnt_s;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1;
   logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0, br_taken = 1'b0, mem_wait = 1'b0;
   logic [3:0] id_type = 4'd0;
   logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;

   logic        stall_if, bubble_ex, flush_if_id, freeze, br_fwd_a, br_fwd_b;
   logic [1:0]  fwd_a, fwd_b, hz_state;
   logic [15:0] stall_cnt;
   logic        s_stall_if, s_bubble_ex, s_flush_if_id, s_freeze, s_br_fwd_a, s_br_fwd_b;
   logic [1:0]  s_fwd_a, s_fwd_b, s_hz_state;
   logic [2:0]  s_stall_cnt;

   exp_t q[$];
   int checks = 0, errors = 0;
   logic [15:0] cnt_model = 16'd0;
   bit done = 1'b0;

   always #5 clk = ~clk;

   hazard_ctrl #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_type(id_type),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .br_taken(br_taken), .mem_wait(mem_wait),
      .stall_if(stall_if), .bubble_ex(bubble_ex), .flush_if_id(flush_if_id), .freeze(freeze),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .br_fwd_a(br_fwd_a), .br_fwd_b(br_fwd_b),
      .hz_state(hz_state), .stall_cnt(stall_cnt)
   );

   hazard_ctrl #(.CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_type(id_type),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .br_taken(br_taken), .mem_wait(mem_wait),
      .stall_if(s_stall_if), .bubble_ex(s_bubble_ex), .flush_if_id(s_flush_if_id),
      .freeze(s_freeze), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .br_fwd_a(s_br_fwd_a),
      .br_fwd_b(s_br_fwd_b), .hz_state(s_hz_state), .stall_cnt(s_stall_cnt)
   );

   function automatic ins_t nop();
      ins_t i = '{1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0};
      return i;
   endfunction
   function automatic ins_t add(int d, int s, int t);
      ins_t i = '{1'b1, 4'd1, 5'(s), 5'(t), 5'(d), 1'b1, 1'b1};
      return i;
   endfunction
   function automatic ins_t lw(int t, int s);
      ins_t i = '{1'b1, 4'd3, 5'(s), 5'(t), 5'd0, 1'b1, 1'b0};
      return i;
   endfunction
   function automatic ins_t beq(int s, int t);
      ins_t i = '{1'b1, 4'd5, 5'(s), 5'(t), 5'd0, 1'b1, 1'b1};
      return i;
   endfunction

   // e = {stall_if,bubble_ex,flush_if_id,freeze, fwd_a, fwd_b, br_fwd_a,br_fwd_b, hz_state}
   task automatic step(input string nm, input ins_t i, input logic br, input logic mw,
                       input logic r, input logic [11:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; mem_wait = mw; br_taken = br;
      id_valid = i.v; id_type = i.t; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
      id_use_rs = i.urs; id_use_rt = i.urt;
      x.nm = nm; x.v = e; x.cnt = cnt_model;
      x.cnt_s = (cnt_model > 16'd7) ? 3'd7 : cnt_model[2:0];
      q.push_back(x);
      if (r)                               cnt_model = 16'd0;
      else if (e[11] && cnt_model != '1)   cnt_model = cnt_model + 16'd1;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t x;
         logic [11:0] got;
         x = q.pop_front();
         got = {stall_if, bubble_ex, flush_if_id, freeze, fwd_a, fwd_b, br_fwd_a, br_fwd_b,
                hz_state};
         checks++;
         if (got !== x.v) begin
            errors++;
            $display("FAIL %s ctrl got %b want %b", x.nm, got, x.v);
         end
         checks++;
         if (stall_cnt !== x.cnt) begin
            errors++;
            $display("FAIL %s stall_cnt got %0d want %0d", x.nm, stall_cnt, x.cnt);
         end
         checks++;
         if (s_stall_cnt !== x.cnt_s) begin
            errors++;
            $display("FAIL %s sat_cnt got %0d want %0d", x.nm, s_stall_cnt, x.cnt_s);
         end
      end
   end

   localparam logic [11:0] Z   = 12'b0000_00_00_00_00;
   localparam logic [11:0] HZ  = 12'b1100_00_00_00_01;
   localparam logic [11:0] FRZ = 12'b1001_00_00_00_10;
   localparam logic [11:0] FL  = 12'b0010_00_00_00_00;
   localparam logic [11:0] FA2 = 12'b0000_10_00_00_00;
   localparam logic [11:0] F11 = 12'b0000_01_01_00_00;

   initial begin
      step("rst0", nop(), 0, 0, 1, Z);
      step("rst1", nop(), 0, 0, 1, Z);
      step("idle", nop(), 0, 0, 0, Z);
      // load-use
      step("lu_lw",   lw(2, 1),     0, 0, 0, Z);
      step("lu_stall", add(3, 2, 4), 0, 0, 0, HZ);
      step("lu_go",   add(3, 2, 4), 0, 0, 0, Z);
      step("lu_fwd",  nop(),        0, 0, 0, FA2);
      step("n", nop(), 0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      // back-to-back ALU forwarding, one-gap, and MEM-over-WB priority
      step("bb_p",  add(2, 1, 1), 0, 0, 0, Z);
      step("bb_c",  add(5, 2, 2), 0, 0, 0, Z);
      step("bb_fwd", nop(),       0, 0, 0, F11);
      step("gap_p", add(2, 1, 1), 0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      step("gap_c", add(6, 2, 7), 0, 0, 0, Z);
      step("gap_fwd", nop(),      0, 0, 0, FA2);
      step("pr_a",  add(2, 1, 1), 0, 0, 0, Z);
      step("pr_b",  add(2, 3, 3), 0, 0, 0, Z);
      step("pr_c",  add(8, 2, 2), 0, 0, 0, Z);
      step("pr_fwd", nop(),       0, 0, 0, F11);
      step("n", nop(), 0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      // writes to $0
      step("z_lw",  lw(0, 1),     0, 0, 0, Z);
      step("z_use", add(3, 0, 0), 0, 0, 0, Z);
      step("z_fwd", nop(),        0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      // branches
      step("br_p",    add(2, 1, 1), 0, 0, 0, Z);
      step("br_haz",  beq(2, 0),    1, 0, 0, HZ);
      step("br_fwdf", beq(2, 0),    1, 0, 0, 12'b0010_00_00_10_00);
      step("br_ex",   nop(),        0, 0, 0, FA2);
      step("bl_lw",   lw(2, 1),     0, 0, 0, Z);
      step("bl_h1",   beq(2, 0),    1, 0, 0, HZ);
      step("bl_h2",   beq(2, 0),    1, 0, 0, HZ);
      step("bl_fl",   beq(2, 0),    1, 0, 0, FL);
      step("n", nop(), 0, 0, 0, Z);
      step("bt_fl",   beq(1, 3),    1, 0, 0, FL);
      step("n", nop(), 0, 0, 0, Z);
      step("bb_add",  add(7, 1, 1), 0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      step("bfb",     beq(1, 7),    0, 0, 0, 12'b0000_00_00_01_00);
      step("bfb_ex",  nop(),        0, 0, 0, 12'b0000_00_10_00_00);
      step("n", nop(), 0, 0, 0, Z);
      // mem_wait during load-use
      step("mw_lw", lw(2, 1),     0, 0, 0, Z);
      step("mw_f1", add(3, 2, 4), 0, 1, 0, FRZ);
      step("mw_f2", add(3, 2, 4), 0, 1, 0, FRZ);
      step("mw_f3", add(3, 2, 4), 0, 1, 0, FRZ);
      step("mw_hz", add(3, 2, 4), 0, 0, 0, HZ);
      step("mw_go", add(3, 2, 4), 0, 0, 0, Z);
      step("mw_fwd", nop(),       0, 0, 0, FA2);
      for (int k = 0; k < 6; k++) step("long_frz", nop(), 0, 1, 0, FRZ);
      step("n", nop(), 0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      step("bw_frz", beq(1, 3), 1, 1, 0, FRZ);
      step("bw_fl",  beq(1, 3), 1, 0, 0, FL);
      // reset during HAZ
      step("rh_lw",  lw(2, 1),     0, 0, 0, Z);
      step("rh_hz",  add(3, 2, 4), 0, 0, 0, HZ);
      step("rh_rst", add(3, 2, 4), 0, 0, 1, Z);
      step("rh_run", add(3, 2, 4), 0, 0, 0, Z);
      step("rh_nof", nop(),        0, 0, 0, Z);
      step("n", nop(), 0, 0, 0, Z);
      done = 1'b1;
   end

   initial begin
      wait (done);
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
